s298_bist_ctrl: RTL and testbench

Built-in self-test controller for the s298 sequential benchmark. It drives the CUT's three primary inputs (G0, G1, G2) from an LFSR pattern source. It compacts the CUT's six primary outputs (G117, G118, G132, G133, G66, G67) into a 16-bit MISR signature and reports pass/fail against a golden value. It is instantiated beside s298 in the layout-generation test harness and shares the CUT clock.

---
 rtl/s298_bist_pkg.sv | 12 +
 rtl/misr16.sv | 18 +
 rtl/s298_bist_ctrl.sv | 72 +++++++
 tb/tb_s298_bist_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/s298_bist_pkg.sv
// s298_bist_pkg: shared states, polynomials and widths for the s298 BIST controller
package s298_bist_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  localparam logic [7:0] LFSR_POLY = 8'h71;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam int MISR_W = 16;
  localparam int CUT_IN_W = 3;
  localparam int CUT_OUT_W = 6;
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], 1'b0} ^ (l[7] ? LFSR_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/misr16.sv
// misr16: 16-bit multiple-input signature register with clear and enable
module misr16 import s298_bist_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CUT_OUT_W-1:0] din,
  output logic [MISR_W-1:0]    sig,
  output logic [MISR_W-1:0]    sig_nxt
);
  assign sig_nxt = clr ? '0
                 : en ? ({sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                         ^ {{(MISR_W-CUT_OUT_W){1'b0}}, din})
                 : sig;
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else sig <= sig_nxt;
endmodule

// File: rtl/s298_bist_ctrl.sv
// s298_bist_ctrl: LFSR pattern source, MISR compactor and test sequencer for the s298 CUT
module s298_bist_ctrl import s298_bist_pkg::*; #(
  parameter int unsigned  INIT_CYCLES = 4,
  parameter int unsigned  PAT_COUNT   = 255,
  parameter logic [7:0]   LFSR_SEED   = 8'h01,
  parameter logic [15:0]  GOLDEN_SIG  = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  input  logic        G117,
  input  logic        G118,
  input  logic        G132,
  input  logic        G133,
  input  logic        G66,
  input  logic        G67,
  output logic        G0,
  output logic        G1,
  output logic        G2,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIG
);
  localparam logic [7:0]  SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] PAT_LAST  = 16'(PAT_COUNT - 1);
  state_t state, nxt;
  logic [15:0] cnt;
  logic [7:0] lfsr;
  logic [CUT_IN_W-1:0] pat;
  logic [MISR_W-1:0] sig_nxt;
  assign {G2, G1, G0} = pat;
  assign BUSY = (state == ST_INIT) || (state == ST_RUN) || (state == ST_DRAIN);
  assign DONE = (state == ST_DONE);
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = START ? ST_INIT : ST_IDLE;
      ST_INIT:  nxt = (cnt == INIT_LAST) ? ST_RUN : ST_INIT;
      ST_RUN:   nxt = (cnt == PAT_LAST) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: nxt = ST_DONE;
      ST_DONE:  nxt = START ? ST_INIT : ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CK or posedge RST)
    if (RST) state <= ST_IDLE;
    else state <= nxt;
  // Pattern flops are loaded from the next state so the CUT sees each state's drive in that state's cycles
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      cnt  <= '0;
      lfsr <= SEED;
      pat  <= '0;
      PASS <= 1'b0;
    end else begin
      cnt  <= (nxt != state || state == ST_IDLE || state == ST_DONE) ? '0 : cnt + 16'd1;
      lfsr <= (nxt == ST_INIT) ? SEED : (nxt == ST_RUN) ? lfsr_step(lfsr) : lfsr;
      pat  <= (nxt == ST_INIT) ? 3'b001 : (nxt == ST_RUN) ? lfsr[CUT_IN_W-1:0] : 3'b000;
      PASS <= (state == ST_DRAIN) ? (sig_nxt == GOLDEN_SIG) : (nxt == ST_DONE) && PASS;
    end
  misr16 u_misr (
    .clk     (CK),
    .rst     (RST),
    .clr     (nxt == ST_INIT),
    .en      (state == ST_RUN || state == ST_DRAIN),
    .din     ({G67, G66, G133, G132, G118, G117}),
    .sig     (SIG),
    .sig_nxt (sig_nxt)
  );
endmodule

// File: tb/tb_s298_bist_ctrl.sv
// tb_s298_bist_ctrl: scoreboard bench with random CUT responses and a signature reference model
module tb_s298_bist_ctrl;
  localparam int INIT_C = 4;
  localparam int PAT_C = 40;
  localparam int N = INIT_C + PAT_C;
  localparam logic [7:0] SEED_C = 8'h00;
  localparam logic [15:0] GOLD_C = 16'h0000;
  typedef struct packed {
    logic [3*N-1:0] g;
    logic [15:0] sig;
    logic pass;
  } exp_t;
  logic CK = 0, RST, START;
  logic [5:0] cut;
  logic G0, G1, G2, BUSY, DONE, PASS;
  logic [15:0] SIG;
  logic mon_en = 0;
  int checks = 0, errors = 0;
  exp_t sbq[$];
  always #5 CK = ~CK;
  s298_bist_ctrl #(.INIT_CYCLES(INIT_C), .PAT_COUNT(PAT_C), .LFSR_SEED(SEED_C), .GOLDEN_SIG(GOLD_C)) dut (
    .CK(CK), .RST(RST), .START(START),
    .G117(cut[0]), .G118(cut[1]), .G132(cut[2]), .G133(cut[3]), .G66(cut[4]), .G67(cut[5]),
    .G0(G0), .G1(G1), .G2(G2), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .SIG(SIG)
  );
  task automatic chk(input string name, input logic [3*N-1:0] act, input logic [3*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // mode 0: all-zero responses, mode 1: START held for the whole test, otherwise random
  task automatic run_txn(input int mode);
    logic [5:0] vin [0:PAT_C];
    exp_t e;
    logic [7:0] l;
    logic [15:0] s;
    for (int j = 0; j <= PAT_C; j++) vin[j] = (mode == 0) ? 6'd0 : 6'($urandom);
    l = (SEED_C == 8'h00) ? 8'h01 : SEED_C;
    e.g = '0;
    for (int i = 0; i < N; i++) begin
      if (i < INIT_C) e.g[3*i +: 3] = 3'b001;
      else begin
        e.g[3*i +: 3] = l[2:0];
        l = {l[6:0], 1'b0} ^ (l[7] ? 8'h71 : 8'h00);
      end
    end
    s = 16'h0000;
    for (int j = 0; j <= PAT_C; j++) s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'd0, vin[j]};
    e.sig = s;
    e.pass = (s == GOLD_C);
    sbq.push_back(e);
    @(negedge CK);
    START = 1;
    @(posedge CK);
    repeat (INIT_C) begin
      @(negedge CK);
      if (mode != 1) START = 0;
      cut = 6'($urandom);
      @(posedge CK);
    end
    for (int j = 0; j <= PAT_C; j++) begin
      @(negedge CK);
      cut = vin[j];
      @(posedge CK);
    end
    @(negedge CK);
    START = 0;
    cut = 6'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge CK) cut = 6'($urandom);
  endtask
  initial begin
    logic busy_prev;
    exp_t e;
    logic [3*N-1:0] gact;
    busy_prev = 0;
    forever begin
      @(posedge CK);
      #1;
      if (mon_en && BUSY && !busy_prev) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got busy=1 expected no test");
        end else begin
          e = sbq.pop_front();
          chk("init_sig_clear", SIG, 0);
          gact = '0;
          for (int i = 0; i < N; i++) begin
            if (i > 0) begin
              @(posedge CK);
              #1;
            end
            gact[3*i +: 3] = {G2, G1, G0};
          end
          chk("pattern_seq", gact, e.g);
          @(posedge CK);
          #1;
          chk("drain_state", {BUSY, DONE, G2, G1, G0}, 5'b10000);
          @(posedge CK);
          #1;
          chk("done_state", {BUSY, DONE, G2, G1, G0}, 5'b01000);
          chk("signature", SIG, e.sig);
          chk("pass_flag", PASS, e.pass);
        end
      end
      busy_prev = BUSY;
    end
  end
  initial begin
    RST = 1;
    START = 0;
    cut = 0;
    repeat (2) @(posedge CK);
    #1;
    chk("reset_g", {G2, G1, G0}, 0);
    chk("reset_flags", {BUSY, DONE, PASS}, 0);
    chk("reset_sig", SIG, 0);
    @(negedge CK);
    RST = 0;
    START = 1;
    @(posedge CK);
    #1;
    chk("start_busy_g0", {BUSY, G0}, 2'b11);
    repeat (INIT_C + 5) @(negedge CK) begin
      START = 0;
      cut = 6'($urandom);
    end
    #2;
    RST = 1;
    #1;
    chk("abort_g", {G2, G1, G0}, 0);
    chk("abort_flags", {BUSY, DONE, PASS}, 0);
    chk("abort_sig", SIG, 0);
    @(negedge CK);
    RST = 0;
    @(posedge CK);
    #1;
    chk("idle_after_abort", {BUSY, DONE, G2, G1, G0}, 0);
    mon_en = 1;
    run_txn(0);
    run_txn(2);
    run_txn(1);
    for (int t = 0; t < 5; t++) run_txn(2);
    run_txn(0);
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(posedge CK);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
